// File: rtl/sensor_uart_scheduler.sv
// Round-robin packetiser sharing one UART TX byte stream between the
// ECG sample stream and the touch-status stream.
module sensor_uart_scheduler #(
   parameter int         ECG_BYTES   = 6,
   parameter int         TOUCH_BYTES = 2,
   parameter logic [7:0] HDR_ECG     = 8'hA5,
   parameter logic [7:0] HDR_TOUCH   = 8'h5A
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     EN,
   input  logic                     ECG_STROBE,
   input  logic [8*ECG_BYTES-1:0]   ECG_DATA,
   input  logic                     TOUCH_STROBE,
   input  logic [8*TOUCH_BYTES-1:0] TOUCH_DATA,
   output logic [7:0]               TX_DATA,
   output logic                     TX_VALID,
   input  logic                     TX_READY,
   input  logic                     OVF_CLR,
   output logic                     ECG_OVF,
   output logic                     TOUCH_OVF,
   output logic                     BUSY,
   output logic [15:0]              PKT_CNT
);

   localparam int EW = 8*ECG_BYTES;
   localparam int TW = 8*TOUCH_BYTES;
   localparam int IW = $clog2(ECG_BYTES+1);

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      PAYLOAD,
      CSUM
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            ecg_full;
   logic            touch_full;
   logic [EW-1:0]   ecg_hold;
   logic [TW-1:0]   touch_hold;
   logic            last_ecg;
   logic            cur_ecg;
   logic [EW-1:0]   shreg;
   logic [7:0]      csum;
   logic [IW-1:0]   idx;
   logic [15:0]     pkt_cnt;
   logic            hs;
   logic            grant_ecg;
   logic            grant_touch;
   logic            grant;
   logic            ecg_cap;
   logic            touch_cap;
   logic            ecg_drop;
   logic            touch_drop;

   assign hs = TX_VALID && TX_READY;

   // Tie goes to whichever source was not served last
   assign grant_ecg   = (state == IDLE) && ecg_full &&
                        (!touch_full || !last_ecg);
   assign grant_touch = (state == IDLE) && touch_full &&
                        (!ecg_full || last_ecg);
   assign grant       = grant_ecg || grant_touch;

   assign ecg_cap    = EN && ECG_STROBE && (!ecg_full || grant_ecg);
   assign touch_cap  = EN && TOUCH_STROBE && (!touch_full || grant_touch);
   assign ecg_drop   = EN && ECG_STROBE && !ecg_cap;
   assign touch_drop = EN && TOUCH_STROBE && !touch_cap;

   assign PKT_CNT = pkt_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (grant) state_nxt = HDR;
         end
         HDR: begin
            if (hs) state_nxt = PAYLOAD;
         end
         PAYLOAD: begin
            if (hs && idx == IW'(1)) state_nxt = CSUM;
         end
         CSUM: begin
            if (hs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      TX_VALID = 1'b0;
      TX_DATA  = 8'h00;
      BUSY     = (state != IDLE);
      unique case (state)
         HDR: begin
            TX_VALID = 1'b1;
            TX_DATA  = cur_ecg ? HDR_ECG : HDR_TOUCH;
         end
         PAYLOAD: begin
            TX_VALID = 1'b1;
            TX_DATA  = shreg[EW-1 -: 8];
         end
         CSUM: begin
            TX_VALID = 1'b1;
            TX_DATA  = csum;
         end
         default: begin
            TX_VALID = 1'b0;
            TX_DATA  = 8'h00;
         end
      endcase
   end

   // Holding registers refill only when empty or emptied this cycle
   always_ff @(posedge CLK) begin
      if (RST) begin
         ecg_full   <= 1'b0;
         touch_full <= 1'b0;
         ecg_hold   <= '0;
         touch_hold <= '0;
         ECG_OVF    <= 1'b0;
         TOUCH_OVF  <= 1'b0;
      end else begin
         if (ecg_cap) begin
            ecg_full <= 1'b1;
            ecg_hold <= ECG_DATA;
         end else if (grant_ecg) begin
            ecg_full <= 1'b0;
         end
         if (touch_cap) begin
            touch_full <= 1'b1;
            touch_hold <= TOUCH_DATA;
         end else if (grant_touch) begin
            touch_full <= 1'b0;
         end
         if (ecg_drop) begin
            ECG_OVF <= 1'b1;
         end else if (OVF_CLR) begin
            ECG_OVF <= 1'b0;
         end
         if (touch_drop) begin
            TOUCH_OVF <= 1'b1;
         end else if (OVF_CLR) begin
            TOUCH_OVF <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         last_ecg <= 1'b0;
         cur_ecg  <= 1'b0;
         shreg    <= '0;
         csum     <= 8'h00;
         idx      <= '0;
         pkt_cnt  <= 16'h0000;
      end else if (grant) begin
         last_ecg <= grant_ecg;
         cur_ecg  <= grant_ecg;
         shreg    <= grant_ecg ? ecg_hold
                               : EW'(touch_hold) << (EW - TW);
         csum     <= 8'h00;
         idx      <= grant_ecg ? IW'(ECG_BYTES) : IW'(TOUCH_BYTES);
      end else if (hs) begin
         if (state == PAYLOAD) begin
            csum  <= csum ^ shreg[EW-1 -: 8];
            shreg <= shreg << 8;
            idx   <= idx - 1'b1;
         end
         if (state == CSUM) begin
            pkt_cnt <= pkt_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sensor_uart_scheduler.sv
// Directed bench for sensor_uart_scheduler: vector table of single
// packets plus hand sequences for arbitration, overflow, EN and reset.
module tb_sensor_uart_scheduler;

   logic        CLK = 1'b0;
   logic        RST;
   logic        EN;
   logic        ECG_STROBE;
   logic [47:0] ECG_DATA;
   logic        TOUCH_STROBE;
   logic [15:0] TOUCH_DATA;
   logic [7:0]  TX_DATA;
   logic        TX_VALID;
   logic        TX_READY;
   logic        OVF_CLR;
   logic        ECG_OVF;
   logic        TOUCH_OVF;
   logic        BUSY;
   logic [15:0] PKT_CNT;

   sensor_uart_scheduler dut (
      .CLK          (CLK),
      .RST          (RST),
      .EN           (EN),
      .ECG_STROBE   (ECG_STROBE),
      .ECG_DATA     (ECG_DATA),
      .TOUCH_STROBE (TOUCH_STROBE),
      .TOUCH_DATA   (TOUCH_DATA),
      .TX_DATA      (TX_DATA),
      .TX_VALID     (TX_VALID),
      .TX_READY     (TX_READY),
      .OVF_CLR      (OVF_CLR),
      .ECG_OVF      (ECG_OVF),
      .TOUCH_OVF    (TOUCH_OVF),
      .BUSY         (BUSY),
      .PKT_CNT      (PKT_CNT)
   );

   always #5 CLK = ~CLK;

   int          checks   = 0;
   int          failures = 0;
   int          valid_cnt = 0;
   logic        stall_prev = 1'b0;
   logic [7:0]  stall_data = 8'h00;
   logic [7:0]  got[$];
   int          exp_cnt;

   typedef struct {
      bit          is_ecg;
      logic [47:0] data;
      bit          toggle;
      int          n;
      logic [7:0]  exp [8];
   } vec_t;

   vec_t vt [7];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Byte monitor plus hold-stable check while stalled
   always @(negedge CLK) begin
      if (RST) begin
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid", 64'(TX_VALID), 64'd1);
            chk("stall_data", 64'(TX_DATA), 64'(stall_data));
         end
         if (TX_VALID && TX_READY) got.push_back(TX_DATA);
         if (TX_VALID) valid_cnt <= valid_cnt + 1;
         stall_prev <= TX_VALID && !TX_READY;
         stall_data <= TX_DATA;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      exp_cnt = 0;
   endtask

   function automatic logic [7:0] gb(int i);
      if (i < got.size()) return got[i];
      return 8'hxx;
   endfunction

   task automatic wait_bytes(int base, int n);
      int cyc;
      cyc = 0;
      while (got.size() - base < n && cyc < 80) begin
         tick();
         cyc++;
      end
      tick();
      tick();
      chk("byte_count", 64'(got.size() - base), 64'(n));
   endtask

   task automatic strobe(bit ecg, logic [47:0] d);
      if (ecg) begin
         ECG_DATA   = d;
         ECG_STROBE = 1'b1;
      end else begin
         TOUCH_DATA   = d[15:0];
         TOUCH_STROBE = 1'b1;
      end
      tick();
      ECG_STROBE   = 1'b0;
      TOUCH_STROBE = 1'b0;
   endtask

   initial begin
      int base;
      int lat;
      int cyc;
      int v0;

      vt[0] = '{1'b1, 48'h123456ABCDEF, 1'b0, 8,
                '{8'hA5, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hF9}};
      vt[1] = '{1'b0, 48'h000000000F03, 1'b1, 4,
                '{8'h5A, 8'h0F, 8'h03, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00}};
      vt[2] = '{1'b1, 48'h000000000000, 1'b1, 8,
                '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
      vt[3] = '{1'b1, 48'hFFFFFFFFFFFF, 1'b0, 8,
                '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00}};
      vt[4] = '{1'b0, 48'h000000008001, 1'b0, 4,
                '{8'h5A, 8'h80, 8'h01, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00}};
      vt[5] = '{1'b1, 48'h010203040506, 1'b1, 8,
                '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}};
      vt[6] = '{1'b0, 48'h00000000FFFF, 1'b1, 4,
                '{8'h5A, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};

      RST = 1'b1; EN = 1'b1; ECG_STROBE = 1'b0; TOUCH_STROBE = 1'b0;
      ECG_DATA = '0; TOUCH_DATA = '0; TX_READY = 1'b1; OVF_CLR = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      exp_cnt = 0;
      chk("rst_valid", 64'(TX_VALID), 64'd0);
      chk("rst_data", 64'(TX_DATA), 64'h00);
      chk("rst_busy", 64'(BUSY), 64'd0);
      chk("rst_ecg_ovf", 64'(ECG_OVF), 64'd0);
      chk("rst_touch_ovf", 64'(TOUCH_OVF), 64'd0);
      chk("rst_pkt_cnt", 64'(PKT_CNT), 64'd0);

      for (int v = 0; v < 7; v++) begin
         base = got.size();
         TX_READY = 1'b1;
         strobe(vt[v].is_ecg, vt[v].data);
         lat = 1;
         while (!TX_VALID && lat < 10) begin
            tick();
            lat++;
         end
         chk("latency", 64'(lat), 64'd2);
         cyc = 0;
         while (BUSY && cyc < 40) begin
            if (vt[v].toggle) TX_READY = ~TX_READY;
            tick();
            cyc++;
         end
         chk("pkt_cycles", 64'(cyc),
             64'(vt[v].toggle ? 2*vt[v].n : vt[v].n));
         chk("pkt_len", 64'(got.size() - base), 64'(vt[v].n));
         for (int i = 0; i < vt[v].n; i++) begin
            chk($sformatf("vec%0d_byte%0d", v, i),
                64'(gb(base + i)), 64'(vt[v].exp[i]));
         end
         exp_cnt++;
         chk("vec_pkt_cnt", 64'(PKT_CNT), 64'(exp_cnt));
         chk("vec_busy", 64'(BUSY), 64'd0);
         TX_READY = 1'b1;
      end

      // Simultaneous strobes: ECG first out of reset
      do_reset();
      base = got.size();
      ECG_DATA = 48'hE1E2E3E4E5E6; TOUCH_DATA = 16'h7172;
      ECG_STROBE = 1'b1; TOUCH_STROBE = 1'b1;
      tick();
      ECG_STROBE = 1'b0; TOUCH_STROBE = 1'b0;
      wait_bytes(base, 12);
      chk("rr1_hdr0", 64'(gb(base)), 64'hA5);
      chk("rr1_pay0", 64'(gb(base + 1)), 64'hE1);
      chk("rr1_hdr1", 64'(gb(base + 8)), 64'h5A);
      chk("rr1_pay1", 64'(gb(base + 9)), 64'h71);
      exp_cnt += 2;
      chk("rr1_cnt", 64'(PKT_CNT), 64'(exp_cnt));
      base = got.size();
      strobe(1'b1, 48'hD1D2D3D4D5D6);
      wait_bytes(base, 8);
      base = got.size();
      ECG_DATA = 48'hC1C2C3C4C5C6; TOUCH_DATA = 16'h6162;
      ECG_STROBE = 1'b1; TOUCH_STROBE = 1'b1;
      tick();
      ECG_STROBE = 1'b0; TOUCH_STROBE = 1'b0;
      wait_bytes(base, 12);
      chk("rr2_hdr0", 64'(gb(base)), 64'h5A);
      chk("rr2_pay0", 64'(gb(base + 1)), 64'h61);
      chk("rr2_hdr1", 64'(gb(base + 4)), 64'hA5);
      chk("rr2_pay1", 64'(gb(base + 5)), 64'hC1);

      // Overflow with a stalled packet
      do_reset();
      TX_READY = 1'b0;
      base = got.size();
      strobe(1'b1, 48'hA1A2A3A4A5A6);
      cyc = 0;
      while (!TX_VALID && cyc < 10) begin
         tick();
         cyc++;
      end
      strobe(1'b1, 48'hB1B2B3B4B5B6);
      chk("ovf_first_held", 64'(ECG_OVF), 64'd0);
      strobe(1'b1, 48'h0C0C0C0C0C0C);
      chk("ovf_second", 64'(ECG_OVF), 64'd1);
      strobe(1'b1, 48'h0D0D0D0D0D0D);
      chk("ovf_third", 64'(ECG_OVF), 64'd1);
      chk("ovf_touch", 64'(TOUCH_OVF), 64'd0);
      OVF_CLR = 1'b1;
      tick();
      OVF_CLR = 1'b0;
      chk("ovf_clr", 64'(ECG_OVF), 64'd0);
      OVF_CLR = 1'b1;
      strobe(1'b1, 48'h0E0E0E0E0E0E);
      OVF_CLR = 1'b0;
      chk("ovf_clr_vs_drop", 64'(ECG_OVF), 64'd1);
      OVF_CLR = 1'b1;
      tick();
      OVF_CLR = 1'b0;
      chk("ovf_clr2", 64'(ECG_OVF), 64'd0);
      chk("ovf_hdr_held", 64'(TX_DATA), 64'hA5);
      TX_READY = 1'b1;
      cyc = 0;
      tick();
      while (BUSY && cyc < 20) begin
         tick();
         cyc++;
      end
      strobe(1'b1, 48'hF1F2F3F4F5F6);
      chk("grant_cycle_strobe", 64'(ECG_OVF), 64'd0);
      wait_bytes(base, 24);
      chk("ovf_pktA", 64'(gb(base + 1)), 64'hA1);
      chk("ovf_pktB", 64'(gb(base + 9)), 64'hB1);
      chk("ovf_pktF", 64'(gb(base + 17)), 64'hF1);
      chk("ovf_hdrF", 64'(gb(base + 16)), 64'hA5);
      chk("ovf_cnt", 64'(PKT_CNT), 64'd3);

      // EN gating
      do_reset();
      EN = 1'b0;
      v0 = valid_cnt;
      ECG_STROBE = 1'b1; TOUCH_STROBE = 1'b1;
      tick();
      ECG_STROBE = 1'b0; TOUCH_STROBE = 1'b0;
      repeat (6) tick();
      chk("en0_no_valid", 64'(valid_cnt - v0), 64'd0);
      chk("en0_busy", 64'(BUSY), 64'd0);
      EN = 1'b1;
      TX_READY = 1'b0;
      base = got.size();
      strobe(1'b1, 48'h313233343536);
      strobe(1'b1, 48'h414243444546);
      EN = 1'b0;
      strobe(1'b1, 48'h515253545556);
      strobe(1'b0, 48'h000000006162);
      chk("en0_no_ecg_ovf", 64'(ECG_OVF), 64'd0);
      chk("en0_no_touch_ovf", 64'(TOUCH_OVF), 64'd0);
      TX_READY = 1'b1;
      wait_bytes(base, 16);
      chk("en0_pkt1", 64'(gb(base + 1)), 64'h31);
      chk("en0_pkt2", 64'(gb(base + 9)), 64'h41);
      chk("en0_cnt", 64'(PKT_CNT), 64'd2);
      EN = 1'b1;

      // Reset in the middle of a payload
      do_reset();
      strobe(1'b1, 48'h112233445566);
      strobe(1'b0, 48'h000000009999);
      cyc = 0;
      while (!TX_VALID && cyc < 10) begin
         tick();
         cyc++;
      end
      repeat (3) tick();
      chk("mid_byte3", 64'(TX_DATA), 64'h33);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("mid_rst_valid", 64'(TX_VALID), 64'd0);
      chk("mid_rst_busy", 64'(BUSY), 64'd0);
      chk("mid_rst_cnt", 64'(PKT_CNT), 64'd0);
      v0 = valid_cnt;
      repeat (10) tick();
      chk("mid_rst_discard", 64'(valid_cnt - v0), 64'd0);

      // Packet counter wrap
      force dut.pkt_cnt = 16'hFFFF;
      #1;
      release dut.pkt_cnt;
      chk("wrap_preset", 64'(PKT_CNT), 64'hFFFF);
      base = got.size();
      strobe(1'b0, 48'h000000001234);
      wait_bytes(base, 4);
      chk("wrap_csum", 64'(gb(base + 3)), 64'h26);
      chk("wrap_cnt", 64'(PKT_CNT), 64'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
